muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine: radix-2 shift-add multiply and restoring divide,
// signed and unsigned, with a start/done handshake and a divide-by-zero flag.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, remf;

    // op[0] selects unsigned, op[1] selects divide
    assign a_neg = ~op_q[0] & a_q[WIDTH-1];
    assign b_neg = ~op_q[0] & b_q[WIDTH-1];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;

    // rem_q stays below the divisor, so the top bit of trial is the borrow
    assign trial = {rem_q, acc_q[WIDTH-1]} - {2'b00, b_q};
    assign sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign prod  = neg_q ? -acc_q : acc_q;
    assign quo   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign remf  = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    busy_d  = 1'b1;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                a_d    = a_mag;
                b_d    = b_mag;
                neg_d  = a_neg ^ b_neg;
                rneg_d = a_neg;
                if (op_q[1] && b_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dz_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    acc_d   = op_q[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (op_q[1]) begin
                    if (!trial[WIDTH+1]) begin
                        rem_d = trial[WIDTH:0];
                        acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
                        acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = S_FIX;
            end
            default: begin
                if (op_q[1]) begin
                    hi_d = remf;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit and an 8-bit instance, each checked every cycle
// against a transaction-level arithmetic model, plus directed literal checks.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_s[2];
    logic [1:0]  op_s[2];
    logic [31:0] a_s[2];
    logic [31:0] b_s[2];

    logic        busy0, done0, dz0, busy1, done1, dz1;
    logic [31:0] hi0, lo0;
    logic [7:0]  hi1, lo1;

    logic        busy_o[2], done_o[2], dz_o[2];
    logic [31:0] hi_o[2], lo_o[2];

    int n_chk = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(rst_n), .start(start_s[0]), .op(op_s[0]),
        .a(a_s[0]), .b(b_s[0]), .busy(busy0), .done(done0),
        .div_zero(dz0), .hi(hi0), .lo(lo0)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst_n), .start(start_s[1]), .op(op_s[1]),
        .a(a_s[1][7:0]), .b(b_s[1][7:0]), .busy(busy1), .done(done1),
        .div_zero(dz1), .hi(hi1), .lo(lo1)
    );

    always_comb begin
        busy_o[0] = busy0;  busy_o[1] = busy1;
        done_o[0] = done0;  done_o[1] = done1;
        dz_o[0]   = dz0;    dz_o[1]   = dz1;
        hi_o[0]   = hi0;    hi_o[1]   = {24'd0, hi1};
        lo_o[0]   = lo0;    lo_o[1]   = {24'd0, lo1};
    end

    // Reference arithmetic: returns {hi, lo}, masked to w bits
    function automatic logic [63:0] model(int unsigned w, logic [1:0] o, logic [31:0] x, logic [31:0] y);
        logic [63:0] mask, sx, sy, p, q, r;
        mask = (64'd1 << w) - 64'd1;
        sx = {32'd0, x} & mask;
        sy = {32'd0, y} & mask;
        if (!o[0]) begin
            if (sx[w-1]) sx = sx | ~mask;
            if (sy[w-1]) sy = sy | ~mask;
        end
        if (!o[1]) begin
            p = sx * sy;
            return {32'((p >> w) & mask), 32'(p & mask)};
        end
        if (o[0]) begin
            q = sx / sy;
            r = sx % sy;
        end else begin
            q = 64'($signed(sx) / $signed(sy));
            r = 64'($signed(sx) % $signed(sy));
        end
        return {32'(r & mask), 32'(q & mask)};
    endfunction

    function automatic logic [31:0] wmask(int unsigned w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: cycles remaining until done, pending result
    logic        m_busy[2], m_done[2], m_dz[2], p_dz[2];
    logic [31:0] m_hi[2], m_lo[2], p_hi[2], p_lo[2];
    int unsigned m_rem[2];

    initial begin
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                int unsigned w;
                logic [63:0] res;
                w = (d == 0) ? 32 : 8;
                m_done[d] = 1'b0;
                m_dz[d]   = 1'b0;
                if (!rst_n) begin
                    m_busy[d] = 1'b0;
                    m_hi[d]   = '0;
                    m_lo[d]   = '0;
                    m_rem[d]  = 0;
                end else if (m_rem[d] != 0) begin
                    m_rem[d]--;
                    if (m_rem[d] == 0) begin
                        m_busy[d] = 1'b0;
                        m_done[d] = 1'b1;
                        m_dz[d]   = p_dz[d];
                        if (!p_dz[d]) begin
                            m_hi[d] = p_hi[d];
                            m_lo[d] = p_lo[d];
                        end
                    end
                end else if (start_s[d]) begin
                    m_busy[d] = 1'b1;
                    if (op_s[d][1] && (b_s[d] & wmask(w)) == 32'd0) begin
                        p_dz[d]  = 1'b1;
                        m_rem[d] = 1;
                    end else begin
                        res      = model(w, op_s[d], a_s[d], b_s[d]);
                        p_hi[d]  = res[63:32];
                        p_lo[d]  = res[31:0];
                        p_dz[d]  = 1'b0;
                        m_rem[d] = w + 2;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("busy[%0d]", d), {31'd0, busy_o[d]}, {31'd0, m_busy[d]});
                    chk($sformatf("done[%0d]", d), {31'd0, done_o[d]}, {31'd0, m_done[d]});
                    chk($sformatf("div_zero[%0d]", d), {31'd0, dz_o[d]}, {31'd0, m_dz[d]});
                    chk($sformatf("hi[%0d]", d), hi_o[d], m_hi[d]);
                    chk($sformatf("lo[%0d]", d), lo_o[d], m_lo[d]);
                end
            end
        end
    end

    task automatic issue(int d, logic [1:0] o, logic [31:0] x, logic [31:0] y);
        start_s[d] = 1'b1;
        op_s[d]    = o;
        a_s[d]     = x;
        b_s[d]     = y;
        @(negedge clk);
        start_s[d] = 1'b0;
        op_s[d]    = 2'($urandom);
        a_s[d]     = $urandom;
        b_s[d]     = $urandom;
    endtask

    task automatic wait_done(int d, output int lat);
        lat = 0;
        while (done_o[d] !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(int d, logic [1:0] o, logic [31:0] x, logic [31:0] y,
                       logic [31:0] eh, logic [31:0] el, int elat, logic edz, string nm);
        int lat;
        issue(d, o, x, y);
        wait_done(d, lat);
        chk({nm, " latency"}, 32'(lat), 32'(elat));
        chk({nm, " hi"}, hi_o[d], eh);
        chk({nm, " lo"}, lo_o[d], el);
        chk({nm, " div_zero"}, {31'd0, dz_o[d]}, {31'd0, edz});
    endtask

    initial begin
        int lat, seen;
        logic [63:0] res;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0;
            op_s[d]    = 2'd0;
            a_s[d]     = '0;
            b_s[d]     = '0;
        end
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset busy", {31'd0, busy0}, 32'd0);
        chk("reset hi", hi0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        res = model(32, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("model multu hi", res[63:32], 32'hFFFF_FFFE);
        chk("model multu lo", res[31:0], 32'h0000_0001);
        res = model(32, 2'b10, 32'hFFFF_FFF9, 32'd2);
        chk("model div hi", res[63:32], 32'hFFFF_FFFF);
        chk("model div lo", res[31:0], 32'hFFFF_FFFD);
        res = model(8, 2'b10, 32'h80, 32'hFF);
        chk("model min/-1 lo", res[31:0], 32'h80);

        run(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 34, 1'b0, "multu32");
        run(0, 2'b00, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 34, 1'b0, "mult32");
        run(0, 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 34, 1'b0, "mult32 min");
        run(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b0, "div32");
        run(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34, 1'b0, "div32 min/-1");
        run(0, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34, 1'b0, "divu32");
        run(0, 2'b10, 32'd1234, 32'd0, 32'd2, 32'd14, 1, 1'b1, "div32 by zero");
        chk("div zero busy", {31'd0, busy0}, 32'd0);

        issue(0, 2'b01, 32'd5, 32'd6);
        repeat (5) @(negedge clk);
        issue(0, 2'b01, 32'd9, 32'd9);
        wait_done(0, lat);
        chk("ignored start latency", 32'(lat + 6), 32'd34);
        chk("ignored start lo", lo0, 32'd30);

        issue(0, 2'b11, 32'd1000, 32'd10);
        wait_done(0, lat);
        chk("b2b first lo", lo0, 32'd100);
        run(0, 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 34, 1'b0, "b2b second");

        issue(0, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid reset busy", {31'd0, busy0}, 32'd0);
        chk("mid reset done", {31'd0, done0}, 32'd0);
        chk("mid reset hi", hi0, 32'd0);
        chk("mid reset lo", lo0, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done0 === 1'b1) seen++;
        end
        chk("no done after reset", 32'(seen), 32'd0);

        run(1, 2'b01, 32'hFF, 32'hFF, 32'hFE, 32'h01, 10, 1'b0, "multu8");
        run(1, 2'b00, 32'hF9, 32'h06, 32'hFF, 32'hD6, 10, 1'b0, "mult8");
        run(1, 2'b10, 32'hF9, 32'h02, 32'hFF, 32'hFD, 10, 1'b0, "div8");
        run(1, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b0, "divu8");
        run(1, 2'b10, 32'h80, 32'hFF, 32'h00, 32'h80, 10, 1'b0, "div8 min/-1");
        run(1, 2'b11, 32'd9, 32'd0, 32'h00, 32'h80, 1, 1'b1, "div8 by zero");

        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                int unsigned r;
                r = $urandom % 16;
                start_s[d] = ($urandom % 3) == 0;
                op_s[d]    = 2'($urandom);
                a_s[d]     = $urandom;
                b_s[d]     = $urandom;
                if (r == 0) b_s[d] = '0;
                if (r == 1) begin
                    a_s[d]  = (d == 0) ? 32'h8000_0000 : 32'h80;
                    b_s[d]  = '1;
                    op_s[d] = 2'b10;
                end
                if (r == 2) begin
                    a_s[d] = $urandom % 20;
                    b_s[d] = $urandom % 5;
                end
            end
            rst_n = ($urandom % 600) != 0;
            @(negedge clk);
        end
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
